// File: rtl/keypoint_stream_tx.sv
// keypoint_stream_tx
// Transmit side of the keypoint/descriptor stream feeding the stereo matcher.
// Keypoints and descriptors are collected during a frame. On frame_end they are
// replayed in write order as a burst of valid beats, followed by a one-cycle
// out_done pulse. Samples offered while the buffer is full are counted as overflow.
module keypoint_stream_tx #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int GAP    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_keypoint,
  input  logic [15:0] in_desc_ch1,
  input  logic [15:0] in_desc_ch2,
  input  logic [15:0] in_desc_ch3,
  input  logic [15:0] in_desc_ch4,
  input  logic        frame_end,
  output logic        out_valid,
  output logic [31:0] out_keypoint,
  output logic [15:0] out_desc_ch1,
  output logic [15:0] out_desc_ch2,
  output logic [15:0] out_desc_ch3,
  output logic [15:0] out_desc_ch4,
  output logic [15:0] out_done,
  output logic        busy,
  output logic [7:0]  overflow_cnt
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_SEND    = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]        GAP_LD   = 4'(GAP);

  // Each entry is {keypoint, ch1, ch2, ch3, ch4}.
  logic [95:0] mem [DEPTH];

  logic              rst_meta_n, rst_sync_n;
  logic [1:0]        state, state_n;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_n;
  logic [ADDR_W:0]   count, count_n;
  logic [ADDR_W:0]   rd_ptr, rd_ptr_n;
  logic [3:0]        gap_cnt, gap_n;
  logic              done_stage, done_stage_n;
  logic [7:0]        ovf_n;
  logic              rd_vld;
  logic [95:0]       rd_data;
  logic              accept, drop, issue;

  // Reset is asserted asynchronously but released only on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_n <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta_n <= 1'b1;
      rst_sync_n <= rst_meta_n;
    end
  end

  assign accept = (state == S_COLLECT) && in_valid && in_ready;
  assign drop   = (state == S_COLLECT) && in_valid && !in_ready;
  // A read is launched when entries remain and the inter-beat gap has elapsed.
  assign issue  = (state == S_SEND) && (rd_ptr != count) && (gap_cnt == 4'd0);

  // Next-state and bookkeeping for collection, burst sequencing and the done pulse.
  always_comb begin
    state_n      = state;
    wr_ptr_n     = wr_ptr;
    count_n      = count;
    rd_ptr_n     = rd_ptr;
    gap_n        = gap_cnt;
    done_stage_n = done_stage;
    ovf_n        = overflow_cnt;
    case (state)
      S_COLLECT: begin
        if (accept) begin
          wr_ptr_n = wr_ptr + PTR_ONE;
          count_n  = count + CNT_ONE;
        end
        if (drop && (overflow_cnt != 8'hFF)) begin
          ovf_n = overflow_cnt + 8'd1;
        end
        if (frame_end) begin
          rd_ptr_n = '0;
          gap_n    = 4'd0;
          if (count_n != '0) begin
            state_n = S_SEND;
          end else begin
            state_n      = S_DONE;
            done_stage_n = 1'b0;
          end
        end
      end
      S_SEND: begin
        if (issue) begin
          rd_ptr_n = rd_ptr + CNT_ONE;
          gap_n    = GAP_LD;
        end else if (gap_cnt != 4'd0) begin
          gap_n = gap_cnt - 4'd1;
        end
        if ((rd_ptr == count) && rd_vld) begin
          state_n      = S_DONE;
          done_stage_n = 1'b1;
        end
      end
      S_DONE: begin
        if (done_stage) begin
          state_n      = S_COLLECT;
          done_stage_n = 1'b0;
          wr_ptr_n     = '0;
          count_n      = '0;
          rd_ptr_n     = '0;
          ovf_n        = 8'd0;
        end else begin
          done_stage_n = 1'b1;
        end
      end
      default: begin
        state_n = S_COLLECT;
      end
    endcase
  end

  // Buffer write during collection and synchronous read during the burst.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= {in_keypoint, in_desc_ch1, in_desc_ch2, in_desc_ch3, in_desc_ch4};
    end
    if (issue) begin
      rd_data <= mem[rd_ptr[ADDR_W-1:0]];
    end
  end

  // State and registered outputs; data outputs are forced to zero between beats.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state        <= S_COLLECT;
      wr_ptr       <= '0;
      count        <= '0;
      rd_ptr       <= '0;
      gap_cnt      <= 4'd0;
      done_stage   <= 1'b0;
      rd_vld       <= 1'b0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_keypoint <= '0;
      out_desc_ch1 <= '0;
      out_desc_ch2 <= '0;
      out_desc_ch3 <= '0;
      out_desc_ch4 <= '0;
      out_done     <= 16'd0;
      busy         <= 1'b0;
      overflow_cnt <= 8'd0;
    end else begin
      state        <= state_n;
      wr_ptr       <= wr_ptr_n;
      count        <= count_n;
      rd_ptr       <= rd_ptr_n;
      gap_cnt      <= gap_n;
      done_stage   <= done_stage_n;
      rd_vld       <= issue;
      in_ready     <= (state_n == S_COLLECT) && (count_n < CNT_FULL);
      out_valid    <= rd_vld;
      out_keypoint <= rd_vld ? rd_data[95:64] : 32'd0;
      out_desc_ch1 <= rd_vld ? rd_data[63:48] : 16'd0;
      out_desc_ch2 <= rd_vld ? rd_data[47:32] : 16'd0;
      out_desc_ch3 <= rd_vld ? rd_data[31:16] : 16'd0;
      out_desc_ch4 <= rd_vld ? rd_data[15:0]  : 16'd0;
      out_done     <= ((state == S_DONE) && done_stage) ? 16'd1 : 16'd0;
      busy         <= (state_n != S_COLLECT);
      overflow_cnt <= ovf_n;
    end
  end

endmodule

// File: tb/tb_keypoint_stream_tx.sv
// tb_keypoint_stream_tx
// Two instances share one stimulus stream: A (DEPTH=4, GAP=0) and B (DEPTH=8, GAP=2).
// A queue-based reference model predicts every output beat and done pulse, with
// the cycle each should appear; a monitor pops and compares as outputs appear.
module tb_keypoint_stream_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_keypoint;
  logic [15:0] in_desc_ch1, in_desc_ch2, in_desc_ch3, in_desc_ch4;
  logic        frame_end;

  logic        in_ready_w  [2];
  logic        out_valid_w [2];
  logic [31:0] out_kp_w    [2];
  logic [15:0] out_c1_w    [2];
  logic [15:0] out_c2_w    [2];
  logic [15:0] out_c3_w    [2];
  logic [15:0] out_c4_w    [2];
  logic [15:0] out_done_w  [2];
  logic        busy_w      [2];
  logic [7:0]  ovf_w       [2];

  typedef struct {
    logic [31:0] kp;
    logic [63:0] ch;
  } sample_t;

  typedef struct {
    bit          is_done;
    logic [31:0] kp;
    logic [63:0] ch;
    int          cyc;
    logic [7:0]  ovf;
  } ev_t;

  sample_t mq    [2][$];
  ev_t     exp_q [2][$];
  int      ovf_m   [2];
  int      depth_m [2];
  int      gap_m   [2];
  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;

  always #5 clk = ~clk;

  // Edge counter: after rising edge k, cyc reads k at the following falling edge.
  always @(posedge clk) cyc <= cyc + 1;

  keypoint_stream_tx #(.DEPTH(4), .ADDR_W(2), .GAP(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_keypoint(in_keypoint), .in_desc_ch1(in_desc_ch1), .in_desc_ch2(in_desc_ch2),
    .in_desc_ch3(in_desc_ch3), .in_desc_ch4(in_desc_ch4), .frame_end(frame_end),
    .out_valid(out_valid_w[0]), .out_keypoint(out_kp_w[0]), .out_desc_ch1(out_c1_w[0]),
    .out_desc_ch2(out_c2_w[0]), .out_desc_ch3(out_c3_w[0]), .out_desc_ch4(out_c4_w[0]),
    .out_done(out_done_w[0]), .busy(busy_w[0]), .overflow_cnt(ovf_w[0])
  );

  keypoint_stream_tx #(.DEPTH(8), .ADDR_W(3), .GAP(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_keypoint(in_keypoint), .in_desc_ch1(in_desc_ch1), .in_desc_ch2(in_desc_ch2),
    .in_desc_ch3(in_desc_ch3), .in_desc_ch4(in_desc_ch4), .frame_end(frame_end),
    .out_valid(out_valid_w[1]), .out_keypoint(out_kp_w[1]), .out_desc_ch1(out_c1_w[1]),
    .out_desc_ch2(out_c2_w[1]), .out_desc_ch3(out_c3_w[1]), .out_desc_ch4(out_c4_w[1]),
    .out_done(out_done_w[1]), .busy(busy_w[1]), .overflow_cnt(ovf_w[1])
  );

  task automatic checkOutput(input string name, input int inst,
                             input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s inst %0d cycle %0d: got %0h expected %0h", name, inst, cyc, act, exp);
    end
  endtask

  // Checks reset-state outputs on both instances.
  task automatic checkResetState();
    for (int i = 0; i < 2; i++) begin
      checkOutput("reset_out_valid", i, 128'(out_valid_w[i]), 128'(0));
      checkOutput("reset_out_done", i, 128'(out_done_w[i]), 128'(0));
      checkOutput("reset_busy", i, 128'(busy_w[i]), 128'(0));
      checkOutput("reset_overflow", i, 128'(ovf_w[i]), 128'(0));
      checkOutput("reset_in_ready", i, 128'(in_ready_w[i]), 128'(1));
      checkOutput("reset_data", i,
                  128'({out_kp_w[i], out_c1_w[i], out_c2_w[i], out_c3_w[i], out_c4_w[i]}), 128'(0));
    end
  endtask

  // Monitor: every output beat or done pulse must match the head of the expected queue.
  always @(negedge clk) begin
    ev_t e;
    for (int i = 0; i < 2; i++) begin
      if (out_valid_w[i] || (out_done_w[i] != 16'd0)) begin
        if (exp_q[i].size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output inst %0d cycle %0d: got valid=%0b done=%0h expected no output",
                   i, cyc, out_valid_w[i], out_done_w[i]);
        end else begin
          e = exp_q[i].pop_front();
          checkOutput("event_cycle", i, 128'(cyc), 128'(e.cyc));
          if (e.is_done) begin
            checkOutput("done_value", i, 128'(out_done_w[i]), 128'(1));
            checkOutput("done_without_beat", i, 128'(out_valid_w[i]), 128'(0));
            checkOutput("done_busy_low", i, 128'(busy_w[i]), 128'(0));
            checkOutput("done_overflow_cleared", i, 128'(ovf_w[i]), 128'(0));
          end else begin
            checkOutput("beat_keypoint", i, 128'(out_kp_w[i]), 128'(e.kp));
            checkOutput("beat_desc", i,
                        128'({out_c1_w[i], out_c2_w[i], out_c3_w[i], out_c4_w[i]}), 128'(e.ch));
            checkOutput("beat_no_done", i, 128'(out_done_w[i]), 128'(0));
            checkOutput("beat_busy", i, 128'(busy_w[i]), 128'(1));
            checkOutput("beat_overflow_hold", i, 128'(ovf_w[i]), 128'(e.ovf));
          end
        end
      end else begin
        checkOutput("idle_data_zero", i,
                    128'({out_kp_w[i], out_c1_w[i], out_c2_w[i], out_c3_w[i], out_c4_w[i]}), 128'(0));
      end
    end
  end

  // Drives one frame of n samples, predicts the burst, and waits for both bursts to end.
  // fe_last puts frame_end on the last sample; abort_at >= 0 resets mid-burst.
  task automatic applyStimulus(input int n, input bit fe_last, input bit rnd_data,
                               input bit sparse, input int abort_at);
    sample_t s;
    ev_t     e;
    int      edge_e;
    int      t;
    bit      ready;
    for (int k = 0; k < n; k++) begin
      if (sparse && ($urandom_range(0, 2) == 0)) begin
        @(negedge clk);
        in_valid  = 1'b0;
        frame_end = 1'b0;
      end
      @(negedge clk);
      if (rnd_data) begin
        s.kp = $urandom;
        s.ch = {$urandom, $urandom};
      end else begin
        s.kp = 32'h0001_0002 + 32'(k);
        s.ch = {16'(k*4+1), 16'(k*4+2), 16'(k*4+3), 16'(k*4+4)};
      end
      in_valid    = 1'b1;
      in_keypoint = s.kp;
      in_desc_ch1 = s.ch[63:48];
      in_desc_ch2 = s.ch[47:32];
      in_desc_ch3 = s.ch[31:16];
      in_desc_ch4 = s.ch[15:0];
      frame_end   = fe_last && (k == n - 1);
      for (int i = 0; i < 2; i++) begin
        ready = (mq[i].size() < depth_m[i]);
        checkOutput("in_ready", i, 128'(in_ready_w[i]), 128'(ready));
        if (ready) mq[i].push_back(s);
        else if (ovf_m[i] < 255) ovf_m[i]++;
      end
    end
    if (!(fe_last && (n > 0))) begin
      @(negedge clk);
      in_valid  = 1'b0;
      frame_end = 1'b1;
    end
    edge_e = cyc + 1;
    // Beat j appears 2 edges after frame_end plus j beat periods; done follows the last beat.
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < mq[i].size(); j++) begin
        e.is_done = 1'b0;
        e.kp      = mq[i][j].kp;
        e.ch      = mq[i][j].ch;
        e.cyc     = edge_e + 2 + j * (gap_m[i] + 1);
        e.ovf     = 8'(ovf_m[i]);
        exp_q[i].push_back(e);
      end
      e.is_done = 1'b1;
      e.kp      = '0;
      e.ch      = '0;
      e.ovf     = 8'd0;
      e.cyc     = (mq[i].size() > 0) ? edge_e + 3 + (mq[i].size() - 1) * (gap_m[i] + 1) : edge_e + 2;
      exp_q[i].push_back(e);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    frame_end = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkOutput("busy_after_frame_end", i, 128'(busy_w[i]), 128'(1));
      checkOutput("in_ready_after_frame_end", i, 128'(in_ready_w[i]), 128'(0));
      checkOutput("overflow_count", i, 128'(ovf_w[i]), 128'(ovf_m[i]));
      mq[i].delete();
      ovf_m[i] = 0;
    end
    t = 0;
    while ((exp_q[0].size() != 0) || (exp_q[1].size() != 0) || busy_w[0] || busy_w[1]) begin
      @(negedge clk);
      t++;
      if ((abort_at >= 0) && (t == abort_at)) begin
        #3;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        frame_end = 1'b0;
        #1;
        checkResetState();
        exp_q[0].delete();
        exp_q[1].delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        break;
      end
      if (t > 4000) begin
        checks++;
        errors++;
        $display("[TB] FAIL burst_timeout cycle %0d: got pending %0d/%0d expected 0", cyc,
                 exp_q[0].size(), exp_q[1].size());
        break;
      end
      // Inputs while both instances are busy must be ignored entirely.
      if (busy_w[0] && busy_w[1]) begin
        in_valid    = 1'($urandom_range(0, 1));
        frame_end   = ($urandom_range(0, 3) == 0);
        in_keypoint = $urandom;
        in_desc_ch1 = 16'($urandom);
      end else begin
        in_valid  = 1'b0;
        frame_end = 1'b0;
      end
    end
    in_valid  = 1'b0;
    frame_end = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput("idle_overflow_zero", i, 128'(ovf_w[i]), 128'(0));
      checkOutput("idle_in_ready", i, 128'(in_ready_w[i]), 128'(1));
      checkOutput("idle_busy", i, 128'(busy_w[i]), 128'(0));
    end
  endtask

  // Directed cases first, then saturation, random frames and a mid-burst reset.
  initial begin
    depth_m[0] = 4;
    depth_m[1] = 8;
    gap_m[0]   = 0;
    gap_m[1]   = 2;
    ovf_m[0]   = 0;
    ovf_m[1]   = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    frame_end   = 1'b0;
    in_keypoint = '0;
    in_desc_ch1 = '0;
    in_desc_ch2 = '0;
    in_desc_ch3 = '0;
    in_desc_ch4 = '0;
    repeat (2) @(negedge clk);
    checkResetState();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    applyStimulus(3, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus(6, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus(2, 1'b1, 1'b0, 1'b0, -1);
    applyStimulus(300, 1'b1, 1'b1, 1'b0, -1);
    repeat (8) applyStimulus(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 1'b1, 1'b1, -1);
    applyStimulus(4, 1'b0, 1'b1, 1'b0, 3);
    applyStimulus(1, 1'b0, 1'b1, 1'b0, -1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
